// File: rtl/result_capture.sv
// Captures one CPU result per rising edge of done into a stamped FWFT FIFO.
// A capture into a full FIFO is dropped and sets a sticky overflow flag.
module result_capture #(
  parameter  int DEPTH   = 4,
  parameter  int STAMP_W = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               done_i,
  input  logic [9:0]         result_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [9:0]         out_data_o,
  output logic [STAMP_W-1:0] out_stamp_o,
  output logic [LW-1:0]      level_o,
  output logic               overflow_o
);

  localparam int EW = STAMP_W + 10;

  typedef enum logic {
    ARMED,
    HELD
  } state_e;

  state_e state_q, state_d;
  logic   cap;

  logic [STAMP_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [EW-1:0]      hold_q;
  logic [EW-1:0]      mem [DEPTH];

  logic          empty, full, pop, wr;
  logic [EW-1:0] show;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (done_i) begin
          cap     = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!done_i) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = !empty && out_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr    = cap && (!full || pop);

  always_comb begin
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    wptr_d  = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    ovf_d   = ovf_q | (cap && full && !pop);
    level_d = level_q;
    unique case ({wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      hold_q  <= show;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr && rst_ni) mem[wptr_q] <= {cnt_q, result_i};
  end

  // Empty FIFO keeps presenting the last head so outputs never go X.
  assign show = empty ? hold_q : mem[rptr_q];

  assign out_valid_o = !empty;
  assign out_data_o  = show[9:0];
  assign out_stamp_o = show[EW-1:10];
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_result_capture.sv
// Random and directed stimulus for result_capture, checked every cycle
// against a queue-based model of the capture/FIFO rules.
module tb_result_capture;

  localparam int DEPTH = 4;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done = 1'b0;
  logic [9:0]    result = '0;
  logic          ready = 1'b0;
  logic          out_valid;
  logic [9:0]    out_data;
  logic [SW-1:0] out_stamp;
  logic [2:0]    level;
  logic          overflow;

  int nvec = 0;
  int nerr = 0;

  result_capture #(.DEPTH(DEPTH), .STAMP_W(SW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .done_i     (done),
    .result_i   (result),
    .out_ready_i(ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_stamp_o(out_stamp),
    .level_o    (level),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] st;
    logic [9:0]    d;
  } ent_t;

  ent_t q[$];
  ent_t m_last = '0;
  bit   m_ovf  = 1'b0;
  bit   m_prev = 1'b0;
  int   m_cnt  = 0;

  // Model: one entry per rising edge of done, stamped with a saturating
  // cycles-since-reset count; a full queue drops unless the head leaves.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_prev = 1'b0;
      m_cnt  = 0;
    end else begin
      int  sz;
      bit  p, c;
      sz = q.size();
      if (sz > 0) m_last = q[0];
      p = (sz > 0) && ready;
      c = done && !m_prev;
      if (p) void'(q.pop_front());
      if (c) begin
        if (sz < DEPTH || p) q.push_back({SW'(m_cnt), result});
        else m_ovf = 1'b1;
      end
      m_prev = done;
      if (m_cnt < 65535) m_cnt++;
    end
  end

  task automatic cmp(string nm, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    e = (q.size() > 0) ? q[0] : m_last;
    cmp("valid", int'(out_valid), int'(q.size() > 0));
    cmp("level", int'(level), q.size());
    cmp("overflow", int'(overflow), int'(m_ovf));
    cmp("data", int'(out_data), int'(e.d));
    cmp("stamp", int'(out_stamp), int'(e.st));
  end

  task automatic step(input bit d, input int r, input bit rdy);
    done   = d;
    result = 10'(r);
    ready  = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cmp("rst_valid", int'(out_valid), 0);
    cmp("rst_level", int'(level), 0);
    cmp("rst_data", int'(out_data), 0);
    cmp("rst_ovf", int'(overflow), 0);
    #1 rst_n = 1'b1;

    // capture at counter 5
    repeat (5) step(0, 0, 0);
    step(1, 'h2A, 0);
    cmp("c5_valid", int'(out_valid), 1);
    cmp("c5_data", int'(out_data), 'h2A);
    cmp("c5_stamp", int'(out_stamp), 5);
    cmp("c5_level", int'(level), 1);
    step(0, 0, 1);
    cmp("c5_hold", int'(out_data), 'h2A);

    // long done pulse gives one entry
    for (int i = 0; i < 20; i++) step(1, 100 + i, 0);
    step(0, 0, 0);
    cmp("long_level", int'(level), 1);
    cmp("long_data", int'(out_data), 100);
    step(0, 0, 1);

    // overflow with ready low
    for (int k = 1; k <= 5; k++) begin
      step(1, k, 0);
      step(0, 0, 0);
    end
    cmp("ovf_level", int'(level), 4);
    cmp("ovf_flag", int'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      cmp("ovf_order", int'(out_data), k);
      step(0, 0, 1);
    end
    cmp("ovf_empty", int'(level), 0);
    cmp("ovf_sticky", int'(overflow), 1);

    // async reset between edges with level 3
    for (int k = 1; k <= 3; k++) begin
      step(1, 'h10 + k, 0);
      step(0, 0, 0);
    end
    cmp("pre_rst_level", int'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_valid", int'(out_valid), 0);
    cmp("arst_level", int'(level), 0);
    cmp("arst_ovf", int'(overflow), 0);
    done   = 1'b1;
    result = 10'h155;
    @(posedge clk);
    @(negedge clk);
    cmp("rst_nocap", int'(level), 0);
    #1 rst_n = 1'b1;
    step(1, 'h155, 0);
    cmp("rel_stamp", int'(out_stamp), 0);
    cmp("rel_data", int'(out_data), 'h155);
    cmp("rel_level", int'(level), 1);

    // capture and pop while full
    step(0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 'h200 + k, 0);
      step(0, 0, 0);
    end
    cmp("full_level", int'(level), 4);
    step(1, 'h3AA, 1);
    cmp("cp_level", int'(level), 4);
    cmp("cp_ovf", int'(overflow), 0);
    cmp("cp_head", int'(out_data), 'h201);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    cmp("cp_tail", int'(out_data), 'h3AA);
    step(0, 0, 1);
    cmp("cp_drained", int'(level), 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit rdy;
      if ((i % 200) < 100) rdy = ($urandom_range(0, 3) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 2) == 0) ? !done : done,
           int'($urandom_range(0, 1023)), rdy);
    end

    // counter saturation
    step(0, 0, 1);
    for (int i = 0; i < 65540; i++) begin
      done  = 1'b0;
      ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    step(1, 'h0F0, 0);
    cmp("sat_stamp", int'(out_stamp), 'hFFFF);
    cmp("sat_data", int'(out_data), 'h0F0);
    step(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
